ccta_seq_alu: RTL and testbench

- Parametrised, registered successor to the team's combinational add/subtract block.
- Accepts operands through a valid/ready handshake, selects one of four arithmetic modes, and returns a registered (WIDTH+1)-bit result with status flags.
- Adds an internal accumulator so that running sums and differences can be built across transactions.
- Sits between operand sources and downstream consumers in the lab datapath.

---
 rtl/ccta_seq_alu.sv | 75 +++++++
 tb/tb_ccta_seq_alu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccta_seq_alu.sv
// Registered add/subtract ALU with accumulator and a single-entry valid/ready output stage.
// Optional CCTA_SAT_EN: saturate on add overflow / subtract borrow instead of wrapping.
module ccta_seq_alu #(
  parameter int WIDTH    = 4,
  parameter int ACC_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH:0]   q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             neg,
  output logic             ovf,
  output logic [WIDTH:0]   acc
);
  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH:0] ACC_RST = W1'(ACC_INIT);

  logic             started;
  logic             accept;
  logic [WIDTH:0]   opa, opb, res;
  logic [WIDTH+1:0] ext;
  logic             flag;

  // started keeps in_ready low until the first edge after reset release
  assign in_ready = started && (!q_valid || q_ready);
  assign accept   = in_valid && in_ready;

  // op[1] selects the accumulator as left operand, op[0] selects subtract
  always_comb begin
    opa  = op[1] ? acc : {1'b0, A};
    opb  = op[0] ? {1'b0, C} : (op[1] ? {1'b0, A} : {1'b0, B});
    ext  = op[0] ? ({1'b0, opa} - {1'b0, opb}) : ({1'b0, opa} + {1'b0, opb});
    flag = ext[WIDTH+1];  // carry on add, borrow on subtract
    res  = ext[WIDTH:0];
`ifdef CCTA_SAT_EN
    if (flag) res = op[0] ? '0 : '1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      q       <= '0;
      q_valid <= 1'b0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
      acc     <= ACC_RST;
    end else begin
      started <= 1'b1;
      if (accept) begin
        q       <= res;
        q_valid <= 1'b1;
        neg     <= op[0] & flag;
        ovf     <= ~op[0] & flag;
        if (op[1]) acc <= res;
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end
      // clear overrides any same-cycle accumulator/flag update; q is unaffected
      if (clr) begin
        acc <= ACC_RST;
        neg <= 1'b0;
        ovf <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ccta_seq_alu.sv
// Self-checking bench for ccta_seq_alu: directed scenarios plus randomized run against a model.
module tb_ccta_seq_alu;
  localparam int W   = 4;
  localparam int MOD = 1 << (W + 1);
`ifdef CCTA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, q_ready = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] A = '0, B = '0, C = '0;
  logic         in_ready, q_valid, neg, ovf;
  logic [W:0]   q, acc;

  int tests = 0;
  int fails = 0;

  ccta_seq_alu #(.WIDTH(W), .ACC_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .C(C), .q(q), .q_valid(q_valid), .q_ready(q_ready),
    .neg(neg), .ovf(ovf), .acc(acc)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int o, input int a, input int b, input int c,
                       input bit qr, input bit cl);
    in_valid = v;
    op       = 2'(o);
    A        = W'(a);
    B        = W'(b);
    C        = W'(c);
    q_ready  = qr;
    clr      = cl;
    #1;
  endtask

  // Reference arithmetic from the mode table, using plain signed integers.
  task automatic ref_op(input int o, input int a, input int b, input int c, input int accv,
                        output int r, output bit n, output bit v);
    int s;
    case (o)
      0:       s = a + b;
      1:       s = a - c;
      2:       s = accv + a;
      default: s = accv - c;
    endcase
    n = 0;
    v = 0;
    if (o % 2 == 1) begin
      n = (s < 0);
      r = (SAT && n) ? 0 : (s + MOD) % MOD;
    end else begin
      v = (s > MOD - 1);
      r = (SAT && v) ? MOD - 1 : s % MOD;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1, 0, 9, 8, 0, 1, 0);
    repeat (3) tick;
    tests++; if (q !== 0)       begin fails++; $display("FAIL reset_q: got %0d want 0", q); end
    tests++; if (q_valid !== 0) begin fails++; $display("FAIL reset_qvalid: got %0b want 0", q_valid); end
    tests++; if (acc !== 0)     begin fails++; $display("FAIL reset_acc: got %0d want 0", acc); end
    tests++; if (in_ready !== 0) begin fails++; $display("FAIL reset_inready: got %0b want 0", in_ready); end
    tests++; if ({neg, ovf} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {neg, ovf}); end
    drive(0, 0, 0, 0, 0, 1, 0);
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 0) begin fails++; $display("FAIL release_inready_pre: got %0b want 0", in_ready); end
    tick;
    tests++; if (in_ready !== 1) begin fails++; $display("FAIL release_inready_post: got %0b want 1", in_ready); end
  endtask

  task automatic test_add;
    drive(1, 0, 9, 8, 0, 1, 0);
    tick;
    tests++; if (q !== 17 || q_valid !== 1 || neg !== 0 || ovf !== 0) begin
      fails++; $display("FAIL add: got q=%0d v=%0b n=%0b o=%0b want 17 1 0 0", q, q_valid, neg, ovf);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    tick;
    tests++; if (q_valid !== 0) begin fails++; $display("FAIL add_consume: got %0b want 0", q_valid); end
  endtask

  task automatic test_sub;
    int expq;
    expq = SAT ? 0 : 30;
    drive(1, 1, 3, 0, 5, 1, 0);
    tick;
    tests++; if (q !== expq || neg !== 1 || ovf !== 0) begin
      fails++; $display("FAIL sub: got q=%0d n=%0b o=%0b want %0d 1 0", q, neg, ovf, expq);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    tick;
  endtask

  task automatic test_backpressure;
    drive(1, 0, 7, 5, 0, 0, 0);
    tick;
    tests++; if (q !== 12 || q_valid !== 1) begin
      fails++; $display("FAIL bp_first: got q=%0d v=%0b want 12 1", q, q_valid);
    end
    drive(1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      tests++; if (q !== 12 || in_ready !== 0 || q_valid !== 1) begin
        fails++; $display("FAIL bp_hold%0d: got q=%0d rdy=%0b v=%0b want 12 0 1", i, q, in_ready, q_valid);
      end
    end
    drive(1, 0, 1, 1, 0, 1, 0);
    tests++; if (in_ready !== 1) begin fails++; $display("FAIL bp_passthru: got %0b want 1", in_ready); end
    tick;
    tests++; if (q !== 2 || q_valid !== 1) begin
      fails++; $display("FAIL bp_release: got q=%0d v=%0b want 2 1", q, q_valid);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    tick;
  endtask

  task automatic test_accumulate;
    int expq [3];
    expq[0] = 15; expq[1] = 30; expq[2] = SAT ? 31 : 13;
    drive(0, 0, 0, 0, 0, 1, 1);
    tick;
    tests++; if (acc !== 0) begin fails++; $display("FAIL acc_clr0: got %0d want 0", acc); end
    drive(1, 2, 15, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++; if (q !== expq[i] || acc !== expq[i] || ovf !== (i == 2) || q_valid !== 1) begin
        fails++; $display("FAIL acc_step%0d: got q=%0d acc=%0d o=%0b want %0d %0d %0b",
                          i, q, acc, ovf, expq[i], expq[i], i == 2);
      end
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    tick;
    tests++; if (acc !== 0 || ovf !== 0) begin
      fails++; $display("FAIL acc_clr: got acc=%0d o=%0b want 0 0", acc, ovf);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_clr_collision;
    int expq;
    expq = SAT ? 0 : 29;
    drive(1, 2, 6, 0, 0, 1, 0);
    tick;
    drive(1, 3, 0, 0, 9, 1, 1);
    tick;
    tests++; if (q !== expq || acc !== 0 || neg !== 0 || q_valid !== 1) begin
      fails++; $display("FAIL clr_collide: got q=%0d acc=%0d n=%0b v=%0b want %0d 0 0 1",
                        q, acc, neg, q_valid, expq);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    tick;
  endtask

  task automatic test_random;
    int m_q, m_acc, r;
    bit m_qv, m_neg, m_ovf, n, ov, v, qr, cl, exp_rdy;
    int o, a, b, c;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick;
    m_q = 0; m_acc = 0; m_qv = 0; m_neg = 0; m_ovf = 0;
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      o  = $urandom_range(0, 3);
      a  = $urandom_range(0, MOD / 2 - 1);
      b  = $urandom_range(0, MOD / 2 - 1);
      c  = $urandom_range(0, MOD / 2 - 1);
      qr = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 15) == 0);
      drive(v, o, a, b, c, qr, cl);
      exp_rdy = !m_qv || qr;
      tests++; if (in_ready !== exp_rdy) begin
        fails++; $display("FAIL rnd_rdy%0d: got %0b want %0b", i, in_ready, exp_rdy);
      end
      if (v && exp_rdy) begin
        ref_op(o, a, b, c, m_acc, r, n, ov);
        m_q = r; m_qv = 1; m_neg = n; m_ovf = ov;
        if (o >= 2) m_acc = r;
      end else if (m_qv && qr) begin
        m_qv = 0;
      end
      if (cl) begin m_acc = 0; m_neg = 0; m_ovf = 0; end
      tick;
      tests++; if (q !== m_q || q_valid !== m_qv || acc !== m_acc || neg !== m_neg || ovf !== m_ovf) begin
        fails++; $display("FAIL rnd_state%0d: got q=%0d v=%0b acc=%0d n=%0b o=%0b want %0d %0b %0d %0b %0b",
                          i, q, q_valid, acc, neg, ovf, m_q, m_qv, m_acc, m_neg, m_ovf);
      end
    end
  endtask

  task automatic test_async_reset;
    drive(0, 0, 0, 0, 0, 1, 1);
    tick;
    drive(1, 2, 15, 0, 0, 1, 0);
    tick;
    drive(1, 2, 5, 0, 0, 1, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    tests++; if (acc !== 20 || q_valid !== 1 || q !== 20) begin
      fails++; $display("FAIL arst_setup: got q=%0d acc=%0d v=%0b want 20 20 1", q, acc, q_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (q !== 0 || q_valid !== 0 || acc !== 0 || in_ready !== 0) begin
      fails++; $display("FAIL arst_immediate: got q=%0d v=%0b acc=%0d rdy=%0b want 0 0 0 0",
                        q, q_valid, acc, in_ready);
    end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_backpressure;
    test_accumulate;
    test_clr_collision;
    test_random;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
